// File: rtl/bp_tag_if.sv
// Fetch/resolve/flush bundle for the branch tag table.
interface bp_tag_if #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 8
);
  logic             lookup_valid;
  logic [PC_W-1:0]  lookup_pc;
  logic             lookup_resp_valid;
  logic             lookup_hit;
  logic [IDX_W-1:0] lookup_index;
  logic             resolve_valid;
  logic [PC_W-1:0]  resolve_pc;
  logic             resolve_taken;
  logic             resolve_ready;
  logic             flush;

  modport master (
    output lookup_valid, lookup_pc,
    output resolve_valid, resolve_pc, resolve_taken,
    output flush,
    input  lookup_resp_valid, lookup_hit, lookup_index,
    input  resolve_ready
  );

  modport slave (
    input  lookup_valid, lookup_pc,
    input  resolve_valid, resolve_pc, resolve_taken,
    input  flush,
    output lookup_resp_valid, lookup_hit, lookup_index,
    output resolve_ready
  );
endinterface

// File: rtl/bp_tag_table.sv
// Branch PC tag table with round-robin allocation and counter-table control.
// Define BP_TAG_PERF_EN to build the resolve hit/miss statistic counters.
module bp_tag_table #(
  parameter int ENTRIES = 4,
  parameter int PC_W    = 32,
  parameter int IDX_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  bp_tag_if.slave          bus,
  output logic             ctr_set,
  output logic [IDX_W-1:0] ctr_set_index,
  output logic             ctr_feedback,
  output logic             ctr_reset,
  output logic [IDX_W-1:0] ctr_reset_index,
  output logic [31:0]      perf_hits,
  output logic [31:0]      perf_misses
);
  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HIT   = 2'd1;
  localparam logic [1:0] S_ALLOC = 2'd2;
  localparam logic [1:0] S_MISS  = 2'd3;

  logic [ENTRIES-1:0] valid_q;
  logic [PC_W-1:0]    tag_q [ENTRIES];
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [1:0]         state_q, state_d;
  logic               taken_q, taken_d;

  logic               set_q, set_d;
  logic               rst_q, rst_d;
  logic               fb_q, fb_d;
  logic [IDX_W-1:0]   set_idx_q, set_idx_d;
  logic [IDX_W-1:0]   rst_idx_q, rst_idx_d;

  logic               rv_q, hit_q;
  logic [IDX_W-1:0]   lidx_q;

  logic               lk_hit, rs_hit;
  logic [IW-1:0]      lk_idx, rs_idx;
  logic               accept, acc_hit, acc_miss;

  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    rs_hit = 1'b0;
    rs_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == bus.lookup_pc) begin
        lk_hit = 1'b1;
        lk_idx = IW'(i);
      end
      if (valid_q[i] && tag_q[i] == bus.resolve_pc) begin
        rs_hit = 1'b1;
        rs_idx = IW'(i);
      end
    end
  end

  assign bus.resolve_ready = reset_n &&
    (state_q == S_IDLE || state_q == S_HIT);
  assign accept   = bus.resolve_valid && bus.resolve_ready;
  // A flush on the same edge drops the resolve entirely
  assign acc_hit  = accept && rs_hit && !bus.flush;
  assign acc_miss = accept && !rs_hit && !bus.flush;

  always_comb begin
    state_d   = S_IDLE;
    set_d     = 1'b0;
    rst_d     = 1'b0;
    set_idx_d = set_idx_q;
    rst_idx_d = rst_idx_q;
    fb_d      = fb_q;
    taken_d   = taken_q;
    ptr_d     = ptr_q;
    if (bus.flush) begin
      ptr_d = '0;
    end else begin
      unique case (state_q)
        S_ALLOC: begin
          state_d   = S_MISS;
          set_d     = 1'b1;
          set_idx_d = rst_idx_q;
          fb_d      = taken_q;
        end
        S_MISS: state_d = S_IDLE;
        default: begin
          if (acc_hit) begin
            state_d   = S_HIT;
            set_d     = 1'b1;
            set_idx_d = IDX_W'(rs_idx);
            fb_d      = bus.resolve_taken;
          end else if (acc_miss) begin
            state_d   = S_ALLOC;
            rst_d     = 1'b1;
            rst_idx_d = IDX_W'(ptr_q);
            taken_d   = bus.resolve_taken;
            ptr_d     = ptr_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q   <= '0;
      ptr_q     <= '0;
      state_q   <= S_IDLE;
      taken_q   <= 1'b0;
      set_q     <= 1'b0;
      rst_q     <= 1'b0;
      fb_q      <= 1'b0;
      set_idx_q <= '0;
      rst_idx_q <= '0;
      rv_q      <= 1'b0;
      hit_q     <= 1'b0;
      lidx_q    <= '0;
    end else begin
      if (bus.flush)
        valid_q <= '0;
      else if (acc_miss)
        valid_q[ptr_q] <= 1'b1;
      ptr_q     <= ptr_d;
      state_q   <= state_d;
      taken_q   <= taken_d;
      set_q     <= set_d;
      rst_q     <= rst_d;
      fb_q      <= fb_d;
      set_idx_q <= set_idx_d;
      rst_idx_q <= rst_idx_d;
      rv_q      <= bus.lookup_valid;
      hit_q     <= bus.lookup_valid && lk_hit;
      lidx_q    <= (bus.lookup_valid && lk_hit) ?
                   IDX_W'(lk_idx) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_miss && reset_n)
      tag_q[ptr_q] <= bus.resolve_pc;
  end

  assign bus.lookup_resp_valid = rv_q;
  assign bus.lookup_hit        = hit_q;
  assign bus.lookup_index      = lidx_q;
  assign ctr_set         = set_q;
  assign ctr_set_index   = set_idx_q;
  assign ctr_feedback    = fb_q;
  assign ctr_reset       = rst_q;
  assign ctr_reset_index = rst_idx_q;

`ifdef BP_TAG_PERF_EN
  logic [31:0] hits_q, miss_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hits_q <= '0;
      miss_q <= '0;
    end else begin
      if (acc_hit)  hits_q <= hits_q + 32'd1;
      if (acc_miss) miss_q <= miss_q + 32'd1;
    end
  end

  assign perf_hits   = hits_q;
  assign perf_misses = miss_q;
`else
  assign perf_hits   = '0;
  assign perf_misses = '0;
`endif
endmodule

// File: tb/tb_bp_tag_table.sv
// Randomized bench for bp_tag_table against a transaction-level table model.
module tb_bp_tag_table;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ctr_set, ctr_feedback, ctr_reset;
  logic [7:0]  ctr_set_index, ctr_reset_index;
  logic [31:0] perf_hits, perf_misses;

  bp_tag_if #(.PC_W(32), .IDX_W(8)) bus ();

  bp_tag_table #(.ENTRIES(N), .PC_W(32), .IDX_W(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus),
    .ctr_set         (ctr_set),
    .ctr_set_index   (ctr_set_index),
    .ctr_feedback    (ctr_feedback),
    .ctr_reset       (ctr_reset),
    .ctr_reset_index (ctr_reset_index),
    .perf_hits       (perf_hits),
    .perf_misses     (perf_misses)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Model: table contents, victim pointer, statistics
  bit          m_valid [N];
  logic [31:0] m_tag [N];
  int          m_ptr, m_ph, m_pm;

  // Expected registered outputs for the coming cycle
  bit e_rv, e_hit, e_set, e_rst, e_fb, e_ready;
  int e_lidx, e_sidx, e_ridx;
  // Pulse owed two cycles out (second half of a miss)
  bit s2_set, s2_fb;
  int s2_idx;

  logic [31:0] pool [8];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find(input logic [31:0] pc);
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_tag[i] == pc) return i;
    return -1;
  endfunction

  task automatic step(input bit rn, input bit lv, input logic [31:0] lpc,
                      input bit rv, input logic [31:0] rpc,
                      input bit rt, input bit fl);
    int h, r;
    bit rdy, miss_next;
    @(negedge clk);
    if (chk_en) begin
      chk("resp_valid", {31'd0, bus.lookup_resp_valid}, {31'd0, e_rv});
      if (e_rv) begin
        chk("hit", {31'd0, bus.lookup_hit}, {31'd0, e_hit});
        chk("lookup_idx", {24'd0, bus.lookup_index}, e_lidx);
      end
      chk("ctr_set", {31'd0, ctr_set}, {31'd0, e_set});
      chk("ctr_reset", {31'd0, ctr_reset}, {31'd0, e_rst});
      if (e_set) begin
        chk("set_idx", {24'd0, ctr_set_index}, e_sidx);
        chk("feedback", {31'd0, ctr_feedback}, {31'd0, e_fb});
      end
      if (e_rst) chk("reset_idx", {24'd0, ctr_reset_index}, e_ridx);
`ifdef BP_TAG_PERF_EN
      chk("perf_hits", perf_hits, m_ph);
      chk("perf_misses", perf_misses, m_pm);
`else
      chk("perf_hits", perf_hits, 32'd0);
      chk("perf_misses", perf_misses, 32'd0);
`endif
    end
    reset_n           = rn;
    bus.lookup_valid  = lv;
    bus.lookup_pc     = lpc;
    bus.resolve_valid = rv;
    bus.resolve_pc    = rpc;
    bus.resolve_taken = rt;
    bus.flush         = fl;
    #1;
    rdy = rn && e_ready;
    if (chk_en) chk("ready", {31'd0, bus.resolve_ready}, {31'd0, rdy});
    chk_en = 1;
    if (!rn) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      m_ptr = 0; m_ph = 0; m_pm = 0;
      e_rv = 0; e_hit = 0; e_lidx = 0;
      e_set = 0; e_rst = 0; s2_set = 0; e_ready = 1;
    end else begin
      h = find(lpc);
      e_rv = lv;
      e_hit = lv && h >= 0;
      e_lidx = e_hit ? h : 0;
      miss_next = s2_set && !fl;
      e_set = miss_next; e_sidx = s2_idx; e_fb = s2_fb;
      e_rst = 0; s2_set = 0;
      if (fl) begin
        for (int i = 0; i < N; i++) m_valid[i] = 0;
        m_ptr = 0;
      end else if (rv && rdy) begin
        r = find(rpc);
        if (r >= 0) begin
          e_set = 1; e_sidx = r; e_fb = rt; m_ph++;
        end else begin
          e_rst = 1; e_ridx = m_ptr;
          s2_set = 1; s2_idx = m_ptr; s2_fb = rt;
          m_tag[m_ptr] = rpc; m_valid[m_ptr] = 1;
          m_ptr = (m_ptr + 1) % N; m_pm++;
        end
      end
      e_ready = !(s2_set || miss_next);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic look(input logic [31:0] pc);
    step(1, 1, pc, 0, 0, 0, 0);
  endtask

  task automatic res(input logic [31:0] pc, input bit t);
    step(1, 0, 0, 1, pc, t, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) pool[i] = 32'h40 * (i + 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h100, 1, 32'h100, 1, 1);
    // first allocation, then lookups hit / miss
    res(32'h100, 1);
    idle(2);
    look(32'h100);
    look(32'h104);
    idle(1);
    // back-to-back hits keep ready high
    res(32'h100, 0);
    res(32'h100, 0);
    idle(2);
    // round-robin wrap
    for (int i = 1; i <= 5; i++) begin
      res(32'h10 * i, i[0]);
      idle(2);
    end
    look(32'h10);
    look(32'h20);
    look(32'h50);
    idle(1);
    // flush during ALLOC
    res(32'h999, 1);
    step(1, 0, 0, 1, 32'h20, 0, 1);
    look(32'h999);
    look(32'h20);
    idle(2);
    // statistics: 2 misses then 3 hits
    step(0, 0, 0, 0, 0, 0, 0);
    res(32'h300, 1); idle(2);
    res(32'h304, 0); idle(2);
    res(32'h300, 0);
    res(32'h304, 1);
    res(32'h300, 1);
    idle(2);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 150) != 0,
           $urandom % 2, pool[$urandom % 8],
           ($urandom % 3) != 0, pool[$urandom % 8],
           $urandom % 2, ($urandom % 40) == 0);
    end
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
